piarb_asa_wrr_arb: RTL and testbench

PIARB_ASA_WRR_ARB -- requirements
Module: piarb_asa_wrr_arb

---
 rtl/piarb_asa_wrr_arb.sv | 189 ++++++++++++++++++
 tb/tb_piarb_asa_wrr_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piarb_asa_wrr_arb.sv
// Weighted round-robin arbiter that merges NREQ requester streams into the
// single write port of the downstream piarb_asa FIFO. An owner keeps the grant
// for weight+1 consecutive entries and loses its turn as soon as it runs dry.

package piarb_asa_pkg;

    // Entry carried from each requester into the FIFO.
    typedef logic [7:0] piarb_asa_meta_type;

endpackage

module piarb_asa_wrr_arb
    import piarb_asa_pkg::*;
#(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned DEPTH_NBITS  = 3,
    parameter int unsigned WEIGHT_NBITS = 2,
    localparam int unsigned PTR_W       = $clog2(NREQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           arb_en_i,
    input  logic [NREQ*WEIGHT_NBITS-1:0]   weight_cfg_i,
    input  logic [NREQ-1:0]                req_valid_i,
    input  piarb_asa_meta_type [NREQ-1:0]  req_meta_i,
    output logic [NREQ-1:0]                req_ready_o,
    input  logic [DEPTH_NBITS:0]           fifo_count_i,
    output logic                           fifo_wr_o,
    output piarb_asa_meta_type             fifo_din_o,
    output logic [PTR_W-1:0]               fifo_wr_id_o
);

    typedef enum logic [0:0] {
        StIdle,
        StOwn
    } state_e;

    localparam int unsigned FIFO_DEPTH = 1 << DEPTH_NBITS;
    localparam logic [DEPTH_NBITS+1:0] DEPTH_LIMIT = (DEPTH_NBITS + 2)'(FIFO_DEPTH);
    localparam logic [DEPTH_NBITS:0] FULL_COUNT = (DEPTH_NBITS + 1)'(FIFO_DEPTH);

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        last_owner_q, last_owner_d;
    logic [WEIGHT_NBITS-1:0] credit_q, credit_d;

    logic                    fifo_wr_q;
    piarb_asa_meta_type      fifo_din_q;
    logic [PTR_W-1:0]        fifo_wr_id_q;

    logic [DEPTH_NBITS+1:0]  occupancy;
    logic                    space_ok;
    logic                    grant_ok;

    logic                    owner_gone;
    logic                    do_search;
    logic [PTR_W-1:0]        search_base;
    logic [PTR_W-1:0]        cand;
    logic [PTR_W-1:0]        search_idx;
    logic                    search_hit;
    logic [WEIGHT_NBITS-1:0] search_weight;

    logic                    grant;
    logic [PTR_W-1:0]        grant_idx;

    // Space check: the write still in flight is not yet in fifo_count_i.
    always_comb begin
        occupancy = {1'b0, fifo_count_i} + {{(DEPTH_NBITS + 1){1'b0}}, fifo_wr_q};
        space_ok  = occupancy < DEPTH_LIMIT;
        grant_ok  = arb_en_i & space_ok;
    end

    // Round-robin search for the next owner, starting just after the last owner.
    always_comb begin
        owner_gone  = (state_q == StOwn) && !req_valid_i[ptr_q];
        // A forfeiting owner becomes the last owner, so it is searched last.
        search_base = owner_gone ? ptr_q : last_owner_q;
        search_hit  = 1'b0;
        search_idx  = '0;
        cand        = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = PTR_W'((int'(search_base) + k) % int'(NREQ));
            if (!search_hit && req_valid_i[cand]) begin
                search_hit = 1'b1;
                search_idx = cand;
            end
        end
        search_weight = weight_cfg_i[search_idx*WEIGHT_NBITS +: WEIGHT_NBITS];
    end

    // Turn FSM: next state, credit bookkeeping and the grant decision.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        credit_d     = credit_q;
        last_owner_d = last_owner_q;
        grant        = 1'b0;
        grant_idx    = ptr_q;
        do_search    = 1'b0;

        unique case (state_q)
            StIdle: begin
                do_search = 1'b1;
            end
            StOwn: begin
                if (owner_gone) begin
                    // Remaining credit is dropped; the search runs in this same cycle.
                    state_d      = StIdle;
                    last_owner_d = ptr_q;
                    do_search    = 1'b1;
                end else if (grant_ok) begin
                    grant    = 1'b1;
                    credit_d = credit_q - WEIGHT_NBITS'(1);
                    if (credit_q == WEIGHT_NBITS'(1)) begin
                        state_d      = StIdle;
                        last_owner_d = ptr_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_search && grant_ok && search_hit) begin
            grant     = 1'b1;
            grant_idx = search_idx;
            ptr_d     = search_idx;
            // Credit counts the grants still owed after this one.
            credit_d  = search_weight;
            if (search_weight != '0) begin
                state_d = StOwn;
            end else begin
                state_d      = StIdle;
                last_owner_d = search_idx;
            end
        end
    end

    // One-hot ready for the granted requester; forced low while in reset.
    always_comb begin
        req_ready_o = '0;
        if (grant && rst_ni) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Arbiter state and registered FIFO write strobe / id.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            credit_q     <= '0;
            last_owner_q <= PTR_W'(NREQ - 1);
            fifo_wr_q    <= 1'b0;
            fifo_wr_id_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            credit_q     <= credit_d;
            last_owner_q <= last_owner_d;
            fifo_wr_q    <= grant;
            if (grant) begin
                fifo_wr_id_q <= grant_idx;
            end
        end
    end

    // Write data register; holds between writes and is not reset.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            fifo_din_q <= req_meta_i[grant_idx];
        end
    end

    assign fifo_wr_o    = fifo_wr_q;
    assign fifo_din_o   = fifo_din_q;
    assign fifo_wr_id_o = fifo_wr_id_q;

`ifndef SYNTHESIS
    // Flag a write landing on an already full FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_ni && fifo_wr_q && (fifo_count_i == FULL_COUNT)) begin
            $error("piarb_asa_wrr_arb: FIFO write while full");
        end
    end
`endif

endmodule

// File: tb/tb_piarb_asa_wrr_arb.sv
// Bench for piarb_asa_wrr_arb: turn-level model of weighted round-robin,
// emulated FIFO occupancy, and directed scenarios with literal sequences.

module tb_piarb_asa_wrr_arb;
    import piarb_asa_pkg::*;

    localparam int NREQ  = 4;
    localparam int DEPTH = 3;
    localparam int FULL  = 1 << DEPTH;

    logic                          clk   = 1'b0;
    logic                          rst_n = 1'b1;
    logic                          arb_en = 1'b0;
    logic [7:0]                    weight_cfg = '0;
    logic [NREQ-1:0]               req_valid = '0;
    piarb_asa_meta_type [NREQ-1:0] req_meta;
    logic [NREQ-1:0]               req_ready;
    logic [DEPTH:0]                fifo_count;
    logic                          fifo_wr;
    piarb_asa_meta_type            fifo_din;
    logic [1:0]                    fifo_wr_id;
    logic                          rd_en = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_log[$];

    // Model: current owner (-1 none), grants left in its turn, last owner.
    int                 m_owner = -1;
    int                 m_left  = 0;
    int                 m_last  = NREQ - 1;
    bit                 exp_wr  = 1'b0;
    int                 exp_id  = 0;
    piarb_asa_meta_type exp_din = '0;

    int s31[$] = '{0, 1, 1, 2, 3, 3, 3, 3, 0, 1, 1, 2, 3, 3, 3, 3};
    int s32[$] = '{1, 1, 2, 3, 0, 1, 1, 1, 1};
    int s34[$] = '{2, 2, 2, 2, 3};
    int s30[$];

    piarb_asa_wrr_arb #(
        .NREQ         (NREQ),
        .DEPTH_NBITS  (DEPTH),
        .WEIGHT_NBITS (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .arb_en_i     (arb_en),
        .weight_cfg_i (weight_cfg),
        .req_valid_i  (req_valid),
        .req_meta_i   (req_meta),
        .req_ready_o  (req_ready),
        .fifo_count_i (fifo_count),
        .fifo_wr_o    (fifo_wr),
        .fifo_din_o   (fifo_din),
        .fifo_wr_id_o (fifo_wr_id)
    );

    always #5 clk = ~clk;

    // Downstream FIFO occupancy; a read pops whatever is present this cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fifo_count <= '0;
        else fifo_count <= fifo_count + {3'b0, fifo_wr}
                           - {3'b0, (rd_en && (fifo_count != 0 || fifo_wr))};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_seq(input string name, input int exp[$]);
        chk({name, "_len"}, wr_log.size(), exp.size());
        foreach (exp[i]) begin
            chk($sformatf("%s_%0d", name, i), (i < wr_log.size()) ? wr_log[i] : -1, exp[i]);
        end
    endtask

    // Per-cycle compare against the turn model, then advance the model.
    task automatic model_step();
        int  g;
        int  idx;
        bit  found;
        if (!rst_n) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_wr", fifo_wr, 0);
            chk("rst_id", fifo_wr_id, 0);
            m_owner = -1;
            m_left  = 0;
            m_last  = NREQ - 1;
            exp_wr  = 1'b0;
            exp_id  = 0;
            return;
        end
        chk("wr", fifo_wr, exp_wr);
        chk("wr_id", fifo_wr_id, exp_id);
        if (exp_wr) chk("din", fifo_din, exp_din);
        chk("no_overflow", (fifo_wr && fifo_count == FULL), 0);
        if (fifo_wr) wr_log.push_back(int'(fifo_wr_id));

        g = -1;
        if (m_owner >= 0 && !req_valid[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
        if (arb_en && (int'(fifo_count) + int'(exp_wr)) < FULL) begin
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (!found && req_valid[idx]) begin
                        found   = 1'b1;
                        m_owner = idx;
                        m_left  = int'(weight_cfg[idx*2 +: 2]) + 1;
                    end
                end
            end
            if (m_owner >= 0) begin
                g = m_owner;
                m_left--;
                if (m_left == 0) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
        chk("ready", req_ready, (g >= 0) ? (1 << g) : 0);
        exp_wr = (g >= 0);
        if (g >= 0) begin
            exp_id  = g;
            exp_din = req_meta[g];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) req_meta[i] = 8'((i << 4) | (cyc & 15));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wr_log.delete();
        req_valid  = '0;
        weight_cfg = '0;
        arb_en     = 1'b1;
        rd_en      = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) req_meta[i] = 8'(i << 4);
        for (int i = 0; i < 12; i++) s30.push_back(i % 4);

        // Reset with requests active: nothing may be readied.
        arb_en    = 1'b1;
        req_valid = 4'hF;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ready_lit", req_ready, 0);

        // Equal weights, drained FIFO: plain rotation, one write per cycle.
        do_reset();
        req_valid = 4'hF;
        repeat (12) tick();
        req_valid = '0;
        repeat (3) tick();
        chk_seq("rot", s30);

        // Weights {3,0,1,0}: 0,1,1,2,3,3,3,3 repeating.
        do_reset();
        weight_cfg = 8'b11_00_01_00;
        req_valid  = 4'hF;
        repeat (16) tick();
        req_valid = '0;
        repeat (3) tick();
        chk_seq("wrr", s31);

        // Owner 1 (weight 3) drops after 2 grants; weight change mid-turn ignored.
        do_reset();
        weight_cfg = 8'b00_00_11_00;
        req_valid  = 4'b1110;
        tick();
        tick();
        req_valid = 4'b1101;
        #1 chk("forfeit_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'b1111;
        repeat (3) tick();
        weight_cfg = 8'h00;
        repeat (3) tick();
        req_valid = '0;
        repeat (3) tick();
        chk_seq("forfeit", s32);

        // No reads: exactly 8 writes, then one read frees exactly one grant.
        do_reset();
        rd_en     = 1'b0;
        req_valid = 4'hF;
        repeat (14) tick();
        chk("fill_writes", wr_log.size(), 8);
        chk("fill_count", fifo_count, FULL);
        chk("fill_ready", req_ready, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        repeat (4) tick();
        chk("one_read_writes", wr_log.size(), 9);
        req_valid = '0;
        repeat (2) tick();

        // arb_en low mid-turn of owner 2; it finishes its turn afterwards.
        do_reset();
        weight_cfg = 8'b00_11_00_00;
        req_valid  = 4'b1100;
        tick();
        tick();
        arb_en = 1'b0;
        #1 chk("hold_ready", req_ready, 0);
        repeat (3) tick();
        chk("hold_writes", wr_log.size(), 2);
        arb_en = 1'b1;
        repeat (3) tick();
        req_valid = '0;
        repeat (3) tick();
        chk_seq("hold", s34);

        // Asynchronous reset mid-turn of owner 2.
        do_reset();
        weight_cfg = 8'hFF;
        req_valid  = 4'b0100;
        tick();
        tick();
        chk("pre_rst_wr", fifo_wr, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_wr", fifo_wr, 0);
        chk("async_rst_ready", req_ready, 0);
        req_valid = 4'b1110;
        tick();
        tick();
        #2 rst_n = 1'b1;
        wr_log.delete();
        repeat (4) tick();
        chk("post_rst_len", wr_log.size(), 3);
        chk("post_rst_first", (wr_log.size() > 0) ? wr_log[0] : -1, 1);
        req_valid = '0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
